// File: rtl/string_reader.sv
// string_reader: streams a null-terminated string from a synchronous ROM, one character per valid/ready handshake.
// Define STRING_READER_WRAP_EN to let addr_o wrap past the top of memory instead of truncating there.
module string_reader #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] start_addr_i,
  output logic [AW-1:0] addr_o,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] char_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          trunc_o
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, SEND, DONE} state_t;

  localparam logic [AW:0]   COUNT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] ADDR_LAST = '1;

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] char_reg, char_next;
  logic          valid_reg, valid_next;
  logic          done_reg, done_next;
  logic          trunc_reg, trunc_next;
  logic [AW:0]   count_reg, count_next;
  logic [AW:0]   count_inc;
  logic [AW-1:0] addr_inc;
  logic          last_char;

  assign count_inc = count_reg + 1'b1;
  assign addr_inc  = addr_reg + 1'b1;

  // The count limit stops a wrapping read of a null-free memory after one full pass.
`ifdef STRING_READER_WRAP_EN
  assign last_char = (count_inc == COUNT_MAX);
`else
  assign last_char = (count_inc == COUNT_MAX) || (addr_reg == ADDR_LAST);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      char_reg  <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      trunc_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      char_reg  <= char_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      trunc_reg <= trunc_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    char_next  = char_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    trunc_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          addr_next  = start_addr_i;
          count_next = '0;
          state_next = ADDR;
        end
      end
      ADDR: state_next = DATA;
      DATA: begin
        if (data_i == '0) begin
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          char_next  = data_i;
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (valid_reg && ready_i) begin
          valid_next = 1'b0;
          addr_next  = addr_inc;
          count_next = count_inc;
          if (last_char) begin
            done_next  = 1'b1;
            trunc_next = 1'b1;
            state_next = DONE;
          end else begin
            state_next = ADDR;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign addr_o  = addr_reg;
  assign char_o  = char_reg;
  assign valid_o = valid_reg;
  assign done_o  = done_reg;
  assign trunc_o = trunc_reg;
  assign busy_o  = (state_reg != IDLE);

endmodule
